// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared constants and entry type for accelerator control logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam int ADDRW_DEFAULT = 24;
  localparam int CHW_DEFAULT   = 2;

  localparam int CH_AES = 0;
  localparam int CH_SHA = 1;

  typedef struct packed {
    logic [CHW_DEFAULT-1:0]   chan;
    logic [ADDRW_DEFAULT-1:0] addr;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin grant over N requesters; the priority pointer
//               moves past the winner only when the caller signals advance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_cand;
  logic          w_found;
  int            w_j;

  // Cyclic search starting one past the previous winner.
  always_comb begin
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = int'(r_last) + k;
      if (w_j >= N) w_j = w_j - N;
      w_cand = IW'(w_j);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign grant     = w_found ? (N'(1) << w_idx) : '0;
  assign grant_idx = w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IW'(N - 1);
    end else if (advance && w_found) begin
      r_last <= w_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/comp_queue_mc.sv
// ============================================================================
// Module      : comp_queue_mc
// Description : Multi-channel completion queue, round-robin write side,
//               FWFT valid/ready read side. Define COMPQ_HWM_EN to add the
//               occupancy high-water mark (hwm_clr / hwm).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_queue_mc
  import ctrl_pkg::*;
#(
  parameter  int ADDRW  = ADDRW_DEFAULT,
  parameter  int NCH    = 4,
  parameter  int QDEPTH = 8,
  localparam int CHW    = $clog2(NCH),
  localparam int CNTW   = $clog2(QDEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       valid_in,
  input  logic [NCH*ADDRW-1:0] dest_addr_in,
  output logic [NCH-1:0]       ready_out,
  output logic [ADDRW-1:0]     data_out,
  output logic [CHW-1:0]       chan_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [CNTW-1:0]      count
`ifdef COMPQ_HWM_EN
  ,
  input  logic                 hwm_clr,
  output logic [CNTW-1:0]      hwm
`endif
);

  localparam int PW = $clog2(QDEPTH);

  typedef struct packed {
    logic [CHW-1:0]   chan;
    logic [ADDRW-1:0] addr;
  } q_entry_t;

  q_entry_t        r_mem [QDEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_run;

  logic [NCH-1:0]  w_grant;
  logic [CHW-1:0]  w_gidx;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [CNTW-1:0] w_count_nxt;
  q_entry_t        w_head;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (valid_in),
    .advance   (w_push),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // Full blocks writes even when a pop is pending in the same cycle.
  assign w_full    = (r_count == CNTW'(QDEPTH));
  assign ready_out = w_grant & {NCH{~w_full & r_run}};
  assign w_push    = |(valid_in & ready_out);

  assign valid_out = (r_count != '0);
  assign w_pop     = valid_out & ready_in;
  assign w_head    = r_mem[r_rd_ptr];
  assign data_out  = valid_out ? w_head.addr : '0;
  assign chan_out  = valid_out ? w_head.chan : '0;
  assign count     = r_count;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{chan: w_gidx, addr: dest_addr_in[w_gidx*ADDRW +: ADDRW]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_run    <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

`ifdef COMPQ_HWM_EN
  logic [CNTW-1:0] r_hwm;

  // Clear reloads the upcoming occupancy rather than zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm <= '0;
    end else if (hwm_clr || (w_count_nxt > r_hwm)) begin
      r_hwm <= w_count_nxt;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

`default_nettype wire

// File: tb/tb_comp_queue_mc.sv
// ============================================================================
// Module      : tb_comp_queue_mc
// Description : Randomized and directed bench for comp_queue_mc against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comp_queue_mc;

  localparam int ADDRW  = 24;
  localparam int NCH    = 4;
  localparam int QDEPTH = 8;
  localparam int CHW    = 2;
  localparam int CNTW   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       valid_in = '0;
  logic [NCH*ADDRW-1:0] dest_addr_in = '0;
  logic [NCH-1:0]       ready_out;
  logic [ADDRW-1:0]     data_out;
  logic [CHW-1:0]       chan_out;
  logic                 valid_out;
  logic                 ready_in = 1'b0;
  logic [CNTW-1:0]      count;
`ifdef COMPQ_HWM_EN
  logic                 hwm_clr = 1'b0;
  logic [CNTW-1:0]      hwm;
`endif

  comp_queue_mc #(.ADDRW(ADDRW), .NCH(NCH), .QDEPTH(QDEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .dest_addr_in (dest_addr_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .chan_out     (chan_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .count        (count)
`ifdef COMPQ_HWM_EN
    ,
    .hwm_clr      (hwm_clr),
    .hwm          (hwm)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int chan;
    int addr;
  } ent_t;

  ent_t mq[$];
  int   m_last = NCH - 1;
  bit   m_run  = 1'b0;
  int   m_hwm  = 0;
  bit   pend[NCH];
  int   paddr[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit rdy, input bit clr);
    int             g;
    int             sz;
    bit             push;
    bit             pop;
    logic [NCH-1:0] exp_ready;
    for (int i = 0; i < NCH; i++) begin
      valid_in[i] = pend[i];
      dest_addr_in[i*ADDRW +: ADDRW] = ADDRW'(paddr[i]);
    end
    ready_in = rdy;
`ifdef COMPQ_HWM_EN
    hwm_clr = clr;
`endif
    #1;
    sz = mq.size();
    g  = -1;
    if (m_run && sz < QDEPTH) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_last + k) % NCH;
        if (g < 0 && pend[c]) g = c;
      end
    end
    exp_ready = (g >= 0) ? NCH'(1 << g) : '0;
    chk("ready_out", 32'(ready_out), 32'(exp_ready));
    chk("valid_out", 32'(valid_out), 32'(sz != 0));
    chk("data_out", 32'(data_out), (sz != 0) ? 32'(mq[0].addr) : 32'd0);
    chk("chan_out", 32'(chan_out), (sz != 0) ? 32'(mq[0].chan) : 32'd0);
    chk("count", 32'(count), 32'(sz));
    push = (g >= 0);
    pop  = (sz != 0) && rdy;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back('{chan: g, addr: paddr[g] & 32'hFFFFFF});
      m_last  = g;
      pend[g] = 1'b0;
    end
    m_run = 1'b1;
    if (clr || mq.size() > m_hwm) m_hwm = mq.size();
    @(negedge clk);
`ifdef COMPQ_HWM_EN
    chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
  endtask

  // Asserts reset between edges, checks the immediate effect, releases on a falling edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_last = NCH - 1;
    m_run  = 1'b0;
    m_hwm  = 0;
    for (int i = 0; i < NCH; i++) pend[i] = 1'b0;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_chan_out", 32'(chan_out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready_out", 32'(ready_out), 32'd0);
    valid_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NCH; i++) pend[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = 0;
    end
    @(negedge clk);
    async_reset();

    // Single push on channel 2; first cycle after release is still blocked.
    pend[2] = 1'b1; paddr[2] = 32'hABCDEF;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("single_valid", 32'(valid_out), 32'd1);
    chk("single_data", 32'(data_out), 32'hABCDEF);
    chk("single_chan", 32'(chan_out), 32'd2);
    chk("single_count", 32'(count), 32'd1);
    cycle(1'b1, 1'b0);

    // All channels requesting, no drain: round-robin fill to full.
    repeat (10) begin
      for (int i = 0; i < NCH; i++)
        if (!pend[i]) begin pend[i] = 1'b1; paddr[i] = int'($urandom_range(0, 32'hFFFFFF)); end
      cycle(1'b0, 1'b0);
    end
    chk("rr_full_count", 32'(count), 32'd8);
    chk("rr_full_ready", 32'(ready_out), 32'd0);

    // Pop while full: no push that cycle, then the next channel refills.
    cycle(1'b1, 1'b0);
    chk("full_pop_count", 32'(count), 32'd7);
    cycle(1'b0, 1'b0);
    chk("refill_count", 32'(count), 32'd8);

    clear_pend();
    repeat (9) cycle(1'b1, 1'b0);

    // Streaming on channel 1 with the sink always ready.
    for (int a = 1; a <= 32; a++) begin
      pend[1] = 1'b1; paddr[1] = a;
      cycle(1'b1, 1'b0);
    end
    repeat (2) cycle(1'b1, 1'b0);

    // Build occupancy 5, then reset in mid-cycle.
    repeat (5) begin
      pend[0] = 1'b1; paddr[0] = int'($urandom_range(0, 32'hFFFFFF));
      cycle(1'b0, 1'b0);
    end
    chk("pre_reset_count", 32'(count), 32'd5);
    async_reset();
    pend[3] = 1'b1; paddr[3] = 32'h123456;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("post_reset_data", 32'(data_out), 32'h123456);
    chk("post_reset_count", 32'(count), 32'd1);
    cycle(1'b1, 1'b0);

`ifdef COMPQ_HWM_EN
    // Fill to 6, drain to 2, then clear.
    repeat (6) begin
      pend[2] = 1'b1; paddr[2] = int'($urandom_range(0, 32'hFFFFFF));
      cycle(1'b0, 1'b0);
    end
    repeat (4) cycle(1'b1, 1'b0);
    chk("hwm_peak", 32'(hwm), 32'd6);
    cycle(1'b0, 1'b1);
    chk("hwm_clear", 32'(hwm), 32'd2);
    repeat (2) cycle(1'b1, 1'b0);
`endif

    // Random traffic with a held-until-accepted producer discipline.
    repeat (500) begin
      for (int i = 0; i < NCH; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = int'($urandom_range(0, 32'hFFFFFF));
        end
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
